// File: rtl/writeback_unit.sv
// Writeback stage: MEM/WB register with load-data extraction, a small FIFO
// for late mult/div results, and arbitration onto the single register-file
// write port. Pipeline results take precedence; queued results fill the
// cycles where the WB register holds a bubble.
module writeback_unit #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              memRegWrite,
    input  logic [4:0]        memRd,
    input  logic              memToReg,
    input  logic [2:0]        memLoadType,
    input  logic [DATA_W-1:0] memAluResult,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              mdValid,
    input  logic [4:0]        mdRd,
    input  logic [DATA_W-1:0] mdResult,
    output logic              mdReady,
    output logic              mdFull,
    output logic              regWrite,
    output logic [4:0]        rWriteAddress,
    output logic [DATA_W-1:0] rWriteValue
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Big-endian sub-word extraction; byte 0 lives in the most significant lane.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [2:0]        lt,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] w
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [DATA_W-1:0]  r;
        case (off)
            2'd0:    b = w[DATA_W-1  -: 8];
            2'd1:    b = w[DATA_W-9  -: 8];
            2'd2:    b = w[DATA_W-17 -: 8];
            default: b = w[DATA_W-25 -: 8];
        endcase
        h = off[1] ? w[DATA_W-17 -: 16] : w[DATA_W-1 -: 16];
        case (lt)
            3'b001:  r = {{(DATA_W-8){b[7]}}, b};
            3'b010:  r = {{(DATA_W-8){1'b0}}, b};
            3'b011:  r = {{(DATA_W-16){h[15]}}, h};
            3'b100:  r = {{(DATA_W-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // ---- stage p0: result selection ahead of the WB register ----
    logic [DATA_W-1:0] mem_val_p0;
    logic              mem_vld_p0;

    // Pick load data or ALU result; $0 writes never become valid.
    always_comb begin
        mem_val_p0 = memToReg ? load_extract(memLoadType, memAluResult[1:0], memReadData)
                              : memAluResult;
        mem_vld_p0 = memRegWrite && (memRd != 5'd0);
    end

    // ---- stage p1: MEM/WB register ----
    logic              wb_vld_p1;
    logic [4:0]        wb_rd_p1;
    logic [DATA_W-1:0] wb_val_p1;

    // WB valid bit: flush or stall inserts a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_vld_p1 <= 1'b0;
        end else if (flush || stall) begin
            wb_vld_p1 <= 1'b0;
        end else begin
            wb_vld_p1 <= mem_vld_p0;
        end
    end

    // WB payload; only meaningful while wb_vld_p1 is set.
    always_ff @(posedge clk) begin
        if (!flush && !stall) begin
            wb_rd_p1  <= memRd;
            wb_val_p1 <= mem_val_p0;
        end
    end

    // ---- mult/div result FIFO ----
    logic [4:0]        fifo_rd  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_val [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              fifo_nempty;

    // Handshake and queue-movement decisions from registered state.
    always_comb begin
        fifo_nempty = (count != '0);
        mdReady     = (count < DEPTH_C);
        mdFull      = (count == DEPTH_C);
        push        = mdValid && mdReady && (mdRd != 5'd0);
        pop         = fifo_nempty && !wb_vld_p1;
    end

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage; entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= mdRd;
            fifo_val[wr_ptr] <= mdResult;
        end
    end

    // Write-port arbitration: pipeline result first, then FIFO head.
    always_comb begin
        regWrite      = 1'b0;
        rWriteAddress = 5'd0;
        rWriteValue   = '0;
        if (wb_vld_p1) begin
            regWrite      = 1'b1;
            rWriteAddress = wb_rd_p1;
            rWriteValue   = wb_val_p1;
        end else if (fifo_nempty) begin
            regWrite      = 1'b1;
            rWriteAddress = fifo_rd[rd_ptr];
            rWriteValue   = fifo_val[rd_ptr];
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, memRegWrite, memToReg, mdValid;
    logic [4:0]  memRd, mdRd;
    logic [2:0]  memLoadType;
    logic [31:0] memAluResult, memReadData, mdResult;
    logic        mdReady, mdFull, regWrite;
    logic [4:0]  rWriteAddress;
    logic [31:0] rWriteValue;

    int checks = 0;
    int passed = 0;

    writeback_unit #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .memRegWrite(memRegWrite), .memRd(memRd), .memToReg(memToReg),
        .memLoadType(memLoadType), .memAluResult(memAluResult),
        .memReadData(memReadData), .mdValid(mdValid), .mdRd(mdRd),
        .mdResult(mdResult), .mdReady(mdReady), .mdFull(mdFull),
        .regWrite(regWrite), .rWriteAddress(rWriteAddress),
        .rWriteValue(rWriteValue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    ent_t        q[$];
    bit          m_wbv   = 1'b0;
    logic [4:0]  m_wbrd  = 5'd0;
    logic [31:0] m_wbval = 32'd0;

    function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] addr,
                                           input logic [31:0] word);
        logic [31:0] v;
        int sh;
        case (lt)
            3'd1, 3'd2: begin
                sh = 8 * (3 - int'(addr % 4));
                v  = (word >> sh) & 32'hFF;
                if (lt == 3'd1 && v >= 32'd128) v = v - 32'd256;
            end
            3'd3, 3'd4: begin
                sh = ((addr / 2) % 2 == 1) ? 0 : 16;
                v  = (word >> sh) & 32'hFFFF;
                if (lt == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    initial begin
        int old_n;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_wbv   = 1'b0;
                m_wbrd  = 5'd0;
                m_wbval = 32'd0;
            end else begin
                old_n = q.size();
                if (!m_wbv && old_n > 0) void'(q.pop_front());
                if (mdValid && old_n < DEPTH && mdRd != 5'd0) q.push_back('{mdRd, mdResult});
                if (flush || stall) begin
                    m_wbv = 1'b0;
                end else begin
                    m_wbv   = memRegWrite && (memRd != 5'd0);
                    m_wbrd  = memRd;
                    m_wbval = memToReg ? m_load(memLoadType, memAluResult, memReadData)
                                       : memAluResult;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        e_we = 1'b0; e_rd = 5'd0; e_val = 32'd0;
        if (m_wbv) begin
            e_we = 1'b1; e_rd = m_wbrd; e_val = m_wbval;
        end else if (q.size() > 0) begin
            e_we = 1'b1; e_rd = q[0].rd; e_val = q[0].val;
        end
        chk("model regWrite", {31'd0, regWrite}, {31'd0, e_we});
        chk("model rWriteAddress", {27'd0, rWriteAddress}, {27'd0, e_rd});
        chk("model rWriteValue", rWriteValue, e_val);
        chk("model mdReady", {31'd0, mdReady}, {31'd0, (q.size() < DEPTH)});
        chk("model mdFull", {31'd0, mdFull}, {31'd0, (q.size() == DEPTH)});
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; memRegWrite = 0; memRd = 0; memToReg = 0;
        memLoadType = 0; memAluResult = 0; memReadData = 0;
        mdValid = 0; mdRd = 0; mdResult = 0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] v);
        memRegWrite = 1; memRd = rd; memToReg = 0; memAluResult = v;
    endtask

    task automatic exp_wr(input string name, input logic we, input logic [4:0] rd,
                          input logic [31:0] v);
        chk({name, " we"}, {31'd0, regWrite}, {31'd0, we});
        chk({name, " addr"}, {27'd0, rWriteAddress}, {27'd0, rd});
        chk({name, " value"}, rWriteValue, v);
    endtask

    typedef struct {
        logic [2:0]  lt;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_t;

    ld_t lv[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time budget expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk); #1;
        exp_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset mdReady", {31'd0, mdReady}, 32'd1);
        chk("reset mdFull", {31'd0, mdFull}, 32'd0);
        rst = 1'b1;
        cyc();

        // Load extraction, each written one cycle after sampling.
        lv.push_back('{3'd1, 32'h100, 32'hFFFFFF80});
        lv.push_back('{3'd2, 32'h101, 32'h000000FF});
        lv.push_back('{3'd3, 32'h102, 32'h00007F01});
        lv.push_back('{3'd4, 32'h100, 32'h000080FF});
        lv.push_back('{3'd0, 32'h100, 32'h80FF7F01});
        lv.push_back('{3'd1, 32'h102, 32'h0000007F});
        lv.push_back('{3'd1, 32'h103, 32'h00000001});
        lv.push_back('{3'd3, 32'h101, 32'hFFFF80FF});
        lv.push_back('{3'd7, 32'h103, 32'h80FF7F01});
        foreach (lv[i]) begin
            memRegWrite = 1; memRd = 5; memToReg = 1; memReadData = 32'h80FF7F01;
            memLoadType = lv[i].lt; memAluResult = lv[i].addr;
            cyc();
            exp_wr($sformatf("load%0d", i), 1'b1, 5'd5, lv[i].exp);
        end
        memToReg = 0; memAluResult = 32'h12345678; memRd = 6;
        cyc();
        exp_wr("alu pass", 1'b1, 5'd6, 32'h12345678);
        idle();
        cyc();
        exp_wr("idle", 1'b0, 5'd0, 32'd0);

        // $0 suppression.
        pipe(5'd0, 32'hDEAD);
        cyc();
        exp_wr("r0 pipe", 1'b0, 5'd0, 32'd0);
        idle();
        mdValid = 1; mdRd = 0; mdResult = 32'hBEEF;
        cyc();
        exp_wr("r0 md", 1'b0, 5'd0, 32'd0);
        chk("r0 md ready", {31'd0, mdReady}, 32'd1);
        idle();
        cyc();
        exp_wr("r0 md after", 1'b0, 5'd0, 32'd0);

        // Arbitration: pipeline overtakes queued mult/div result.
        pipe(5'd3, 32'h33); mdValid = 1; mdRd = 7; mdResult = 32'h11;
        cyc();
        exp_wr("arb r3 first", 1'b1, 5'd3, 32'h33);
        mdValid = 0; pipe(5'd3, 32'h34);
        cyc();
        exp_wr("arb r3 second", 1'b1, 5'd3, 32'h34);
        idle();
        cyc();
        exp_wr("arb r7", 1'b1, 5'd7, 32'h11);
        cyc();
        exp_wr("arb drained", 1'b0, 5'd0, 32'd0);

        // FIFO full and drain.
        pipe(5'd3, 32'h1); mdValid = 1; mdRd = 8; mdResult = 32'h88;
        cyc();
        chk("fill1 full", {31'd0, mdFull}, 32'd0);
        mdRd = 9; mdResult = 32'h99;
        cyc();
        chk("fill2 full", {31'd0, mdFull}, 32'd1);
        chk("fill2 ready", {31'd0, mdReady}, 32'd0);
        mdRd = 10; mdResult = 32'hAA;
        cyc();
        chk("fill3 full", {31'd0, mdFull}, 32'd1);
        exp_wr("fill3 wb", 1'b1, 5'd3, 32'h1);
        mdValid = 0; stall = 1;
        cyc();
        exp_wr("drain r8", 1'b1, 5'd8, 32'h88);
        chk("drain1 full", {31'd0, mdFull}, 32'd1);
        cyc();
        exp_wr("drain r9", 1'b1, 5'd9, 32'h99);
        chk("drain2 full", {31'd0, mdFull}, 32'd0);
        idle();
        cyc();
        exp_wr("drain done", 1'b0, 5'd0, 32'd0);
        chk("drain ready", {31'd0, mdReady}, 32'd1);

        // Flush and stall bubbles.
        pipe(5'd4, 32'h44); flush = 1;
        cyc();
        exp_wr("flush", 1'b0, 5'd0, 32'd0);
        flush = 0; stall = 1;
        cyc();
        exp_wr("stall empty", 1'b0, 5'd0, 32'd0);
        flush = 1;
        cyc();
        exp_wr("flush+stall", 1'b0, 5'd0, 32'd0);
        idle();

        // Reset during activity.
        pipe(5'd3, 32'h2); mdValid = 1; mdRd = 12; mdResult = 32'hC;
        cyc();
        mdRd = 13; mdResult = 32'hD;
        cyc();
        chk("pre-reset full", {31'd0, mdFull}, 32'd1);
        rst = 1'b0;
        #1;
        exp_wr("async reset", 1'b0, 5'd0, 32'd0);
        chk("async reset ready", {31'd0, mdReady}, 32'd1);
        chk("async reset full", {31'd0, mdFull}, 32'd0);
        cyc();
        chk("reset md ignored", {31'd0, mdReady}, 32'd1);
        idle();
        rst = 1'b1;
        cyc();
        exp_wr("post-reset 1", 1'b0, 5'd0, 32'd0);
        cyc();
        exp_wr("post-reset 2", 1'b0, 5'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage of the mips32 pipeline: the producer side of the register file's single write port.
- Holds the MEM/WB pipeline register and performs load-data extraction for lw/lb/lbu/lh/lhu.
- Buffers late results from the multi-cycle mult/div unit in a small FIFO.
- Arbitrates between pipeline results and buffered results so at most one register write is issued per cycle, on regWrite/rWriteAddress/rWriteValue.

Parameters:
FIFO_DEPTH, 2, entries in the mult/div result FIFO; power of two, >= 2
DATA_W, 32, datapath width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low
stall  input  1  MEM stage held by hazard unit; WB register loads a bubble
flush  input  1  squash MEM-stage instruction; WB register loads a bubble
memRegWrite  input  1  MEM-stage instruction writes a register
memRd  input  5  destination register of MEM-stage instruction
memToReg  input  1  1 = result from memory (load), 0 = ALU result
memLoadType  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw
memAluResult  input  DATA_W  ALU result / load byte address
memReadData  input  DATA_W  raw word returned by data memory
mdValid  input  1  mult/div result offered this cycle
mdRd  input  5  mult/div destination register
mdResult  input  DATA_W  mult/div result
mdReady  output  1  FIFO can accept (count < FIFO_DEPTH)
mdFull  output  1  FIFO full; hazard unit uses it to stall
regWrite  output  1  register-file write enable
rWriteAddress  output  5  register-file write address
rWriteValue  output  DATA_W  register-file write data

Behaviour:
- Reset (rst=0, asynchronous):
  - WB valid=0, FIFO count=0, read/write pointers=0.
  - regWrite=0, rWriteAddress=0, rWriteValue=0, mdFull=0, mdReady=1.
  - mdValid is ignored while rst=0.
  - Reset mid-operation discards all pending FIFO entries and the WB entry.
- Load extraction (combinational, before the WB register), big-endian, offset = memAluResult[1:0]:
  - lb/lbu: offset 0 selects bits 31:24, offset 1 selects 23:16, offset 2 selects 15:8, offset 3 selects 7:0.
  - lh/lhu: memAluResult[1]=0 selects 31:16, =1 selects 15:0; memAluResult[0] is ignored.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - memToReg=0 passes memAluResult unchanged.
- WB register, each rising edge, priority order:
  - flush → valid<=0.
  - else stall → valid<=0.
  - else valid<=memRegWrite && memRd!=0, and rd/value are captured.
  - Writes to $0 are never issued.
- FIFO:
  - Push when mdValid && mdReady && mdRd!=0; an mdRd=0 entry is accepted but dropped.
  - Pop when the FIFO is non-empty and WB valid=0.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - mdReady and mdFull are derived from the registered count only.
- Output arbitration (combinational from registered state only; no input-to-output path):
  - WB valid=1 → regWrite=1 with the WB rd/value; the FIFO head waits.
  - Else FIFO non-empty → regWrite=1 with the head rd/value.
  - Else regWrite=0, address=0, value=0.
- Latency:
  - Pipeline result sampled at edge N is presented during cycle N→N+1.
  - An mdResult accepted at edge N is presented no earlier than cycle N→N+1, and only in a cycle with WB valid=0.
- Ordering: FIFO entries write in acceptance order. Pipeline writes may overtake queued mult/div writes. The hazard unit guarantees no RAW dependence on a queued rd.
- Starvation avoidance: the hazard unit stalls when mdFull=1. Stall forces WB bubbles, so the FIFO drains one entry per stalled cycle.

Test Plan:
- Reset during activity: 2 FIFO entries plus a valid WB entry, pull rst low between edges → regWrite=0, mdReady=1, mdFull=0 immediately; after release, no stale write appears.
- Load extraction: memReadData=0x80FF7F01, memToReg=1, memRd=5. Required values:
  - lb with offset 0 → 0xFFFFFF80.
  - lbu with offset 1 → 0x000000FF.
  - lh with memAluResult[1]=1 → 0x00007F01.
  - lhu with memAluResult[1]=0 → 0x000080FF.
  - lw → 0x80FF7F01.
  - Each is written one cycle after sampling.
- $0 suppression: memRegWrite=1, memRd=0; then mdValid with mdRd=0 → regWrite never asserts; FIFO count stays 0.
- Arbitration: mdResult=0x11 to r7 pushed while pipeline writes r3 on consecutive cycles → r3 writes first; r7 writes in the first cycle WB valid=0.
- FIFO full and drain (FIFO_DEPTH=2): push r8, r9 while WB is busy → mdFull=1, mdReady=0. Third mdValid is not accepted. Assert stall for 2 cycles → writes r8 then r9, and mdFull clears after the first pop.
- flush vs stall: flush=1 with memRegWrite=1, rd=4 → no write to r4. Stall=1 while the FIFO is empty → regWrite=0 that cycle.
